// File: rtl/anc_pkg.sv
// Shared types for the ANC adaptive filter datapath (delay, MAC and LMS blocks).
package anc_pkg;

    localparam int SAMPLE_W = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } tap_state_t;

endpackage

// File: rtl/tap_ring_ram.sv
// Circular sample history: one synchronous write port, one asynchronous read port, async clear.
module tap_ring_ram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]        raddr,
    output logic signed [DATA_W-1:0] rdata
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tap_history_reader.sv
// Stores one reference sample per frame and streams x[n] .. x[n-NTAPS+1] to the MAC engine.
module tap_history_reader
    import anc_pkg::*;
#(
    parameter  int DATA_W = SAMPLE_W,
    parameter  int NTAPS  = 8,
    localparam int IDX_W  = $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] tap_data,
    output logic [IDX_W-1:0]         tap_idx,
    output logic                     tap_valid,
    input  logic                     tap_ready,
    output logic                     tap_last,
    output logic                     overrun
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NTAPS - 1);

    tap_state_t state, state_nxt;
    logic [IDX_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [IDX_W-1:0] rd_k, rd_k_nxt;
    logic [IDX_W-1:0] waddr, rd_addr;
    logic signed [DATA_W-1:0] data_nxt, rd_data;
    logic we;

    // wr_ptr always points at the newest sample, so tap k+1 lives at wr_ptr-(k+1).
    assign waddr   = wr_ptr + IDX_W'(1);
    assign rd_addr = wr_ptr - rd_k - IDX_W'(1);

    tap_ring_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (NTAPS)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (in_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_k     <= '0;
            tap_data <= '0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            rd_k     <= rd_k_nxt;
            tap_data <= data_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_k_nxt   = rd_k;
        data_nxt   = tap_data;
        we         = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    we         = 1'b1;
                    wr_ptr_nxt = waddr;
                    rd_k_nxt   = '0;
                    data_nxt   = in_data;
                    state_nxt  = STREAM;
                end
            end
            STREAM: begin
                if (tap_ready) begin
                    if (rd_k == LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        rd_k_nxt = rd_k + IDX_W'(1);
                        data_nxt = rd_data;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags decode straight from registered state, so they drop with rst.
    assign in_ready  = (state == IDLE);
    assign tap_valid = (state == STREAM);
    assign tap_idx   = rd_k;
    assign tap_last  = tap_valid && (rd_k == LAST);
    assign overrun   = in_valid && !in_ready;

endmodule

// File: tb/tb_tap_history_reader.sv
// Directed bench for tap_history_reader with NTAPS = 8, DATA_W = 32.
module tb_tap_history_reader;
    import anc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    sample_t     in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    sample_t     tap_data;
    logic [2:0]  tap_idx;
    logic        tap_valid;
    logic        tap_ready = 1'b0;
    logic        tap_last;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    sample_t    cap_data [8];
    logic [2:0] cap_idx  [8];
    logic       cap_last [8];
    int         cap_n;

    tap_history_reader #(
        .DATA_W (32),
        .NTAPS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tap_data  (tap_data),
        .tap_idx   (tap_idx),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .tap_last  (tap_last),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Offer one sample once in_ready is seen; afterwards tap k=0 should be on the outputs.
    task automatic push(input sample_t s);
        for (int i = 0; i < 50 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_wait: in_ready=%b required 1 (timeout)", in_ready);
        end
        in_valid = 1'b1;
        in_data  = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Collect one frame with tap_ready held high; no checking here.
    task automatic drain();
        cap_n = 0;
        tap_ready = 1'b1;
        for (int c = 0; c < 50 && cap_n < 8; c++) begin
            if (tap_valid) begin
                cap_data[cap_n] = tap_data;
                cap_idx[cap_n]  = tap_idx;
                cap_last[cap_n] = tap_last;
                cap_n++;
            end
            @(posedge clk); #1;
        end
        tap_ready = 1'b0;
    endtask

    task automatic test_reset();
        sample_t exp [8];
        exp = '{32'sd1, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if ({tap_valid, tap_last, overrun, tap_idx} !== 6'b0 || tap_data !== 32'sd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b ovr=%b idx=%0d data=%0d ready=%b required 0,0,0,0,0,1",
                     tap_valid, tap_last, overrun, tap_idx, tap_data, in_ready);
        end
        push(32'sd1);
        drain();
        checks++;
        if (cap_n !== 8) begin
            errors++;
            $display("FAIL reset_frame_len: got %0d taps required 8", cap_n);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_data[k] !== exp[k] || cap_idx[k] !== 3'(k)) begin
                errors++;
                $display("FAIL reset_frame_tap%0d: data=%0d idx=%0d required data=%0d idx=%0d",
                         k, cap_data[k], cap_idx[k], exp[k], k);
            end
        end
    endtask

    task automatic test_fill();
        sample_t exp [8];
        exp = '{32'sd8, 32'sd7, 32'sd6, 32'sd5, 32'sd4, 32'sd3, 32'sd2, 32'sd1};
        for (int s = 2; s <= 8; s++) begin
            push(sample_t'(s));
            drain();
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_data[k] !== exp[k] || cap_idx[k] !== 3'(k) || cap_last[k] !== (k == 7)) begin
                errors++;
                $display("FAIL fill_tap%0d: data=%0d idx=%0d last=%b required data=%0d idx=%0d last=%b",
                         k, cap_data[k], cap_idx[k], cap_last[k], exp[k], k, (k == 7));
            end
        end
        checks++;
        if (tap_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_return_idle: valid=%b ready=%b required 0,1", tap_valid, in_ready);
        end
    endtask

    task automatic test_wrap();
        sample_t exp [8];
        exp = '{32'sd11, 32'sd10, 32'sd9, 32'sd8, 32'sd7, 32'sd6, 32'sd5, 32'sd4};
        for (int s = 9; s <= 11; s++) begin
            push(sample_t'(s));
            drain();
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL wrap_tap%0d: data=%0d required %0d", k, cap_data[k], exp[k]);
            end
        end
        push(-32'sd5);
        checks++;
        if (tap_data !== 32'hFFFF_FFFB || tap_idx !== 3'd0) begin
            errors++;
            $display("FAIL wrap_signed: data=%h idx=%0d required fffffffb idx=0", tap_data, tap_idx);
        end
        drain();
        checks++;
        if (cap_data[1] !== 32'sd11 || cap_data[7] !== 32'sd5) begin
            errors++;
            $display("FAIL wrap_signed_frame: tap1=%0d tap7=%0d required 11,5", cap_data[1], cap_data[7]);
        end
    endtask

    task automatic test_backpressure();
        sample_t exp [8];
        logic [3:0] pat;
        sample_t prev_d;
        logic [2:0] prev_i;
        logic have_prev;
        exp = '{32'sd100, -32'sd5, 32'sd11, 32'sd10, 32'sd9, 32'sd8, 32'sd7, 32'sd6};
        pat = 4'b1001;
        have_prev = 1'b0;
        prev_d = '0;
        prev_i = '0;
        push(32'sd100);
        cap_n = 0;
        for (int c = 0; c < 60 && cap_n < 8; c++) begin
            if (tap_valid) begin
                if (have_prev) begin
                    checks++;
                    if (tap_data !== prev_d || tap_idx !== prev_i) begin
                        errors++;
                        $display("FAIL bp_stable: data=%0d idx=%0d required data=%0d idx=%0d",
                                 tap_data, tap_idx, prev_d, prev_i);
                    end
                end
                tap_ready = pat[c % 4];
                if (tap_ready) begin
                    cap_data[cap_n] = tap_data;
                    cap_idx[cap_n]  = tap_idx;
                    cap_n++;
                    have_prev = 1'b0;
                end else begin
                    prev_d = tap_data;
                    prev_i = tap_idx;
                    have_prev = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        tap_ready = 1'b0;
        checks++;
        if (cap_n !== 8) begin
            errors++;
            $display("FAIL bp_frame_len: got %0d taps required 8", cap_n);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_data[k] !== exp[k] || cap_idx[k] !== 3'(k)) begin
                errors++;
                $display("FAIL bp_tap%0d: data=%0d idx=%0d required data=%0d idx=%0d",
                         k, cap_data[k], cap_idx[k], exp[k], k);
            end
        end
    endtask

    task automatic test_overrun();
        sample_t exp [8];
        exp = '{32'sd300, 32'sd200, 32'sd100, -32'sd5, 32'sd11, 32'sd10, 32'sd9, 32'sd8};
        push(32'sd200);
        tap_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'sd999;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (overrun !== 1'b1 || tap_idx !== 3'd0 || tap_data !== 32'sd200) begin
                errors++;
                $display("FAIL overrun_cycle%0d: ovr=%b idx=%0d data=%0d required 1,0,200",
                         i, overrun, tap_idx, tap_data);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b required 0", overrun);
        end
        drain();
        push(32'sd300);
        drain();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL overrun_next_tap%0d: data=%0d required %0d", k, cap_data[k], exp[k]);
            end
        end
    endtask

    task automatic test_edge();
        sample_t exp [8];
        exp = '{32'sd500, 32'sd400, 32'sd300, 32'sd200, 32'sd100, -32'sd5, 32'sd11, 32'sd10};
        push(32'sd400);
        tap_ready = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = 32'sd777;
        #1;
        checks++;
        if (tap_last !== 1'b1 || tap_idx !== 3'd7 || overrun !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL edge_last_overrun: last=%b idx=%0d ovr=%b ready=%b required 1,7,1,0",
                     tap_last, tap_idx, overrun, in_ready);
        end
        @(posedge clk); #1;
        in_data = 32'sd500;
        #1;
        checks++;
        if (tap_valid !== 1'b0 || in_ready !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL edge_idle: valid=%b ready=%b ovr=%b required 0,1,0", tap_valid, in_ready, overrun);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (tap_valid !== 1'b1 || tap_data !== 32'sd500 || tap_idx !== 3'd0) begin
            errors++;
            $display("FAIL edge_accept: valid=%b data=%0d idx=%0d required 1,500,0", tap_valid, tap_data, tap_idx);
        end
        drain();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_data[k] !== exp[k]) begin
                errors++;
                $display("FAIL edge_frame_tap%0d: data=%0d required %0d", k, cap_data[k], exp[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        push(32'sd600);
        tap_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        tap_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tap_valid !== 1'b0 || tap_data !== 32'sd0 || tap_idx !== 3'd0 || tap_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%b data=%0d idx=%0d last=%b required 0,0,0,0",
                     tap_valid, tap_data, tap_idx, tap_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: in_ready=%b required 1", in_ready);
        end
        push(32'sd1);
        drain();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap_data[k] !== ((k == 0) ? 32'sd1 : 32'sd0)) begin
                errors++;
                $display("FAIL reset_mid_tap%0d: data=%0d required %0d", k, cap_data[k], (k == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_backpressure();
        test_overrun();
        test_edge();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
